// File: rtl/tinyalu_arbiter_if.sv
// rtl/tinyalu_arbiter_if.sv - requester, response and ALU pin bundle for tinyalu_arbiter
interface tinyalu_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic [3*NUM_REQ-1:0] req_op;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [15:0]          rsp_result;
  logic                 rsp_err;
  logic                 alu_start;
  logic [2:0]           alu_op;
  logic [7:0]           alu_a;
  logic [7:0]           alu_b;
  logic                 alu_done;
  logic [15:0]          alu_result;

  // Arbiter side: accepts requests, returns responses, drives the ALU pins.
  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_done, alu_result,
    output req_ready, rsp_valid, rsp_result, rsp_err,
    output alu_start, alu_op, alu_a, alu_b
  );

  modport master (
    output req_valid, req_a, req_b, req_op, alu_done, alu_result,
    input  req_ready, rsp_valid, rsp_result, rsp_err,
    input  alu_start, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/tinyalu_arbiter.sv
// rtl/tinyalu_arbiter.sv - round-robin arbiter sharing one tinyalu between NUM_REQ requesters
module tinyalu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  tinyalu_arbiter_if.slave bus
);

  localparam int         IDX_W  = $clog2(NUM_REQ);
  localparam int         CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   gnt_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [15:0]        rsp_result_q;
  logic               rsp_err_q;
  logic               alu_start_q;
  logic [2:0]         alu_op_q;
  logic [7:0]         alu_a_q;
  logic [7:0]         alu_b_q;

  logic [IDX_W-1:0]   gnt_d;
  logic               gnt_found;
  logic [NUM_REQ-1:0] gnt_oh_d;
  logic [NUM_REQ-1:0] rsp_oh;
  logic [IDX_W-1:0]   rr_next;
  logic [2:0]         sel_op_d;
  logic [7:0]         sel_a_d;
  logic [7:0]         sel_b_d;
  logic               is_alu_op_d;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int j;
    j         = 0;
    gnt_d     = rr_ptr_q;
    gnt_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!gnt_found && bus.req_valid[IDX_W'(j)]) begin
        gnt_found = 1'b1;
        gnt_d     = IDX_W'(j);
      end
    end
  end

  assign sel_op_d    = bus.req_op[3*int'(gnt_d) +: 3];
  assign sel_a_d     = bus.req_a[8*int'(gnt_d) +: 8];
  assign sel_b_d     = bus.req_b[8*int'(gnt_d) +: 8];
  assign is_alu_op_d = (sel_op_d != OP_NOP) && (sel_op_d <= OP_MUL);
  assign gnt_oh_d    = NUM_REQ'(1) << gnt_d;
  assign rsp_oh      = NUM_REQ'(1) << gnt_q;
  assign rr_next     = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;

  // Gated by reset_n so every output reads 0 while reset is held.
  assign bus.req_ready  = (reset_n && state_q == IDLE && gnt_found) ? gnt_oh_d : '0;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.alu_start  = alu_start_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      gnt_q        <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      alu_start_q  <= 1'b0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            gnt_q <= gnt_d;
            cnt_q <= '0;
            if (is_alu_op_d) begin
              state_q     <= BUSY;
              alu_start_q <= 1'b1;
              alu_op_q    <= sel_op_d;
              alu_a_q     <= sel_a_d;
              alu_b_q     <= sel_b_d;
            end else begin
              // no_op and illegal opcodes are answered without touching the ALU.
              state_q      <= RESP;
              rsp_valid_q  <= gnt_oh_d;
              rsp_result_q <= '0;
              rsp_err_q    <= (sel_op_d != OP_NOP);
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus.alu_done || cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q      <= RESP;
            rsp_valid_q  <= rsp_oh;
            rsp_result_q <= bus.alu_done ? bus.alu_result : 16'h0000;
            rsp_err_q    <= !bus.alu_done;
            alu_start_q  <= 1'b0;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
          end
        end
        RESP: begin
          rr_ptr_q <= rr_next;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// tb/tb_tinyalu_arbiter.sv - directed scoreboard bench for tinyalu_arbiter
module tb_tinyalu_arbiter;
  localparam int         NR     = 4;
  localparam int         TO     = 15;
  localparam logic [2:0] ADD    = 3'b001;
  localparam logic [2:0] XOR_OP = 3'b011;
  localparam logic [2:0] MUL    = 3'b100;

  typedef struct {
    int          idx;
    logic [15:0] res;
    logic        err;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  tinyalu_arbiter_if #(.NUM_REQ(NR)) bus ();
  tinyalu_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int          checks  = 0;
  int          errors  = 0;
  int          acc_cnt = 0;
  int          rsp_cnt = 0;
  int          alu_lat = 1;
  int          scnt    = 0;
  exp_t        sb[$];
  logic        force_done = 1'b0;
  logic        start_seen = 1'b0;
  logic        done_r     = 1'b0;
  logic [15:0] res_r      = 16'h0000;
  logic [7:0]  rr_a[NR]   = '{8'h3C, 8'hA5, 8'h0F, 8'hFF};
  logic [7:0]  rr_b[NR]   = '{8'hC3, 8'h5A, 8'hF0, 8'h81};

  assign bus.alu_done   = done_r;
  assign bus.alu_result = res_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int idx, input logic [15:0] res, input logic err);
    exp_t e;
    e.idx = idx;
    e.res = res;
    e.err = err;
    sb.push_back(e);
    acc_cnt++;
  endtask

  task automatic drive(input int idx, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.req_op[3*idx +: 3] = op;
    bus.req_a[8*idx +: 8]  = a;
    bus.req_b[8*idx +: 8]  = b;
    bus.req_valid[idx]     = 1'b1;
  endtask

  // Returns #1 after the negedge of the accept cycle.
  task automatic wait_accept(output int g, output int waited);
    g      = -1;
    waited = 0;
    #1;
    while (bus.req_ready == '0 && waited < 40) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk("accept_seen", 32'(bus.req_ready != '0), 32'd1);
    for (int i = 0; i < NR; i++) if (bus.req_ready[i]) g = i;
  endtask

  // Returns at the negedge of cycle 1 (accept = cycle 0).
  task automatic issue(input int idx, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] res, input logic err, input bit keep, output int waited);
    int g;
    drive(idx, op, a, b);
    wait_accept(g, waited);
    chk("grant_idx", 32'(g), 32'(idx));
    if (keep) push(idx, res, err);
    @(negedge clk);
    bus.req_valid[idx] = 1'b0;
  endtask

  // ALU model: done in the alu_lat-th cycle of start (0 = never).
  always @(negedge clk) begin
    if (bus.alu_start) scnt++;
    else scnt = 0;
    done_r = force_done || (alu_lat != 0 && bus.alu_start && scnt == alu_lat);
    case (bus.alu_op)
      3'b001:  res_r = {8'h00, bus.alu_a} + {8'h00, bus.alu_b};
      3'b010:  res_r = {8'h00, bus.alu_a & bus.alu_b};
      3'b011:  res_r = {8'h00, bus.alu_a ^ bus.alu_b};
      3'b100:  res_r = {8'h00, bus.alu_a} * {8'h00, bus.alu_b};
      default: res_r = 16'hDEAD;
    endcase
  end

  // Scoreboard pop and per-cycle protocol checks.
  always @(negedge clk) begin
    if (bus.alu_start) start_seen = 1'b1;
    chk("ready_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
    chk("rsp_onehot", 32'($countones(bus.rsp_valid) <= 1), 32'd1);
    chk("ready_only_idle", 32'(bus.req_ready != '0 && (bus.alu_start || bus.rsp_valid != '0)), 32'd0);
    if (bus.rsp_valid != '0) begin
      rsp_cnt++;
      chk("sb_pending", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_valid_idx", 32'(bus.rsp_valid), 32'(4'(1) << e.idx));
        chk("rsp_result", 32'(bus.rsp_result), 32'(e.res));
        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
      end
    end
  end

  initial begin
    int g;
    int w;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_alu_start", 32'(bus.alu_start), 32'd0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
    chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
    chk("rst_alu_b", 32'(bus.alu_b), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // All four requesters continuously valid with xor
    alu_lat = 1;
    for (int i = 0; i < NR; i++) drive(i, XOR_OP, rr_a[i], rr_b[i]);
    for (int k = 0; k < 5; k++) begin
      wait_accept(g, w);
      chk("rr_grant", 32'(g), 32'(k % NR));
      if (g >= 0) push(g, {8'h00, rr_a[g] ^ rr_b[g]}, 1'b0);
      @(negedge clk);
    end
    bus.req_valid = '0;
    repeat (3) @(negedge clk);

    // Single add from requester 1
    issue(1, ADD, 8'h12, 8'h34, 16'h0046, 1'b0, 1'b1, w);
    chk("add_start_c1", 32'(bus.alu_start), 32'd1);
    chk("add_op_c1", 32'(bus.alu_op), 32'(ADD));
    chk("add_a_c1", 32'(bus.alu_a), 32'h12);
    chk("add_b_c1", 32'(bus.alu_b), 32'h34);
    @(negedge clk);
    chk("add_start_c2", 32'(bus.alu_start), 32'd0);
    chk("add_rsp_c2", 32'(bus.rsp_valid), 32'b0010);
    chk("add_result", 32'(bus.rsp_result), 32'h0046);
    chk("add_err", 32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    chk("add_rsp_c3", 32'(bus.rsp_valid), 32'd0);

    // mul from requester 0, done in the third start cycle
    alu_lat = 3;
    issue(0, MUL, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b1, w);
    for (int c = 1; c <= 3; c++) begin
      chk("mul_start_held", 32'(bus.alu_start), 32'd1);
      chk("mul_op_held", 32'(bus.alu_op), 32'(MUL));
      chk("mul_a_held", 32'(bus.alu_a), 32'hFF);
      @(negedge clk);
    end
    chk("mul_start_c4", 32'(bus.alu_start), 32'd0);
    chk("mul_rsp_c4", 32'(bus.rsp_valid), 32'b0001);
    chk("mul_result", 32'(bus.rsp_result), 32'hFE01);
    @(negedge clk);

    // Illegal op then no_op from requester 2
    start_seen = 1'b0;
    issue(2, 3'b110, 8'h55, 8'h66, 16'h0000, 1'b1, 1'b1, w);
    chk("ill_rsp_c1", 32'(bus.rsp_valid), 32'b0100);
    chk("ill_err", 32'(bus.rsp_err), 32'd1);
    chk("ill_result", 32'(bus.rsp_result), 32'd0);
    issue(2, 3'b000, 8'h55, 8'h66, 16'h0000, 1'b0, 1'b1, w);
    chk("nop_next_accept", 32'(w), 32'd1);
    chk("nop_rsp_c1", 32'(bus.rsp_valid), 32'b0100);
    chk("nop_err", 32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    chk("nop_no_start", 32'(start_seen), 32'd0);

    // alu_done while idle must be ignored
    force_done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_done_norsp", 32'(bus.rsp_valid), 32'd0);
      chk("idle_done_nostart", 32'(bus.alu_start), 32'd0);
    end
    force_done = 1'b0;
    @(negedge clk);

    // Timeout: add with done held low
    alu_lat = 0;
    issue(3, ADD, 8'h01, 8'h02, 16'h0000, 1'b1, 1'b1, w);
    for (int c = 1; c <= TO; c++) begin
      chk("to_start_held", 32'(bus.alu_start), 32'd1);
      chk("to_no_rsp", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
    end
    chk("to_rsp_c16", 32'(bus.rsp_valid), 32'b1000);
    chk("to_err", 32'(bus.rsp_err), 32'd1);
    chk("to_result", 32'(bus.rsp_result), 32'd0);
    chk("to_start_drop", 32'(bus.alu_start), 32'd0);
    alu_lat = 1;
    issue(0, ADD, 8'h03, 8'h04, 16'h0007, 1'b0, 1'b1, w);
    chk("to_next_accept", 32'(w), 32'd1);
    chk("to_next_start", 32'(bus.alu_start), 32'd1);
    @(negedge clk);
    chk("to_next_result", 32'(bus.rsp_result), 32'h0007);
    @(negedge clk);

    // Reset pulsed during BUSY of a mul; the op is dropped
    alu_lat = 0;
    issue(3, MUL, 8'h09, 8'h09, 16'h0000, 1'b0, 1'b0, w);
    drive(1, ADD, 8'h05, 8'h06);
    drive(2, ADD, 8'h07, 8'h08);
    @(negedge clk);
    chk("rmid_start_busy", 32'(bus.alu_start), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rmid_alu_start", 32'(bus.alu_start), 32'd0);
    chk("rmid_alu_op", 32'(bus.alu_op), 32'd0);
    chk("rmid_alu_a", 32'(bus.alu_a), 32'd0);
    chk("rmid_alu_b", 32'(bus.alu_b), 32'd0);
    chk("rmid_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rmid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rmid_rsp_result", 32'(bus.rsp_result), 32'd0);
    chk("rmid_rsp_err", 32'(bus.rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    alu_lat = 1;
    wait_accept(g, w);
    chk("rmid_first_grant", 32'(g), 32'd1);
    push(1, 16'h000B, 1'b0);
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    wait_accept(g, w);
    chk("rmid_second_grant", 32'(g), 32'd2);
    push(2, 16'h000F, 1'b0);
    @(negedge clk);
    bus.req_valid[2] = 1'b0;
    repeat (4) @(negedge clk);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("rsp_per_accept", 32'(rsp_cnt), 32'(acc_cnt));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
